pattern_detect_scheduler: RTL and testbench

Time-multiplexes one shared serial pattern-detection engine across NCH independent serial bit-stream requesters. A round-robin arbiter accepts at most one bit per cycle via valid/ready handshakes. Per-channel detection history is saved and restored around each access. A one-cycle match strobe, tagged with the channel index, is reported to downstream logic.

---
 rtl/pattern_detect_scheduler.sv | 98 +++++++++
 tb/tb_pattern_detect_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detect_scheduler.sv
// Round-robin scheduler sharing one serial pattern detector across NCH bit-stream channels.
// Optional saturating match counter enabled by defining PATTERN_SCHED_COUNT_EN.
module pattern_detect_scheduler #(
    parameter int unsigned        NCH     = 4,
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int unsigned        COUNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH-1:0]           ch_bit,
    output logic [NCH-1:0]           ch_ready,
    output logic                     match_valid,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic [COUNT_W-1:0]       match_total
);

    localparam int unsigned CH_W   = $clog2(NCH);
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_any;
    logic [PAT_LEN-1:0] hist_q [NCH];
    logic [FILL_W-1:0]  fill_q [NCH];
    logic [PAT_LEN-1:0] new_hist;
    logic [FILL_W-1:0]  fill_next;
    logic               hit;

    // NCH is a power of two, so CH_W-bit wraparound gives the modulo search order.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!grant_any && ch_valid[CH_W'(ptr_q + CH_W'(k))]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(ptr_q + CH_W'(k));
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        if (grant_any) begin
            ch_ready[grant_idx] = 1'b1;
        end
        ptr_d = grant_any ? CH_W'(grant_idx + 1'b1) : ptr_q;
    end

    always_comb begin
        new_hist  = {hist_q[grant_idx][PAT_LEN-2:0], ch_bit[grant_idx]};
        fill_next = (fill_q[grant_idx] == FILL_W'(PAT_LEN)) ? fill_q[grant_idx]
                                                            : fill_q[grant_idx] + 1'b1;
        // fill+1 >= PAT_LEN: the new bit completes a full window for this channel.
        hit = grant_any && (new_hist == PATTERN) &&
              (fill_q[grant_idx] >= FILL_W'(PAT_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            match_valid <= hit;
            if (hit) begin
                match_ch <= grant_idx;
            end
            if (grant_any) begin
                hist_q[grant_idx] <= new_hist;
                fill_q[grant_idx] <= fill_next;
            end
        end
    end

`ifdef PATTERN_SCHED_COUNT_EN
    logic [COUNT_W-1:0] total_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
        end else if (hit && (total_q != '1)) begin
            total_q <= total_q + 1'b1;
        end
    end

    assign match_total = total_q;
`else
    assign match_total = '0;
`endif

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// Self-checking bench for pattern_detect_scheduler: stream-level reference model plus directed tests.
module tb_pattern_detect_scheduler;

    localparam int NCH     = 4;
    localparam int PAT_LEN = 3;
    localparam int CW      = 2;
    localparam logic [PAT_LEN-1:0] PAT = 3'b101;
`ifdef PATTERN_SCHED_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_valid;
    logic [NCH-1:0] ch_bit;
    logic [NCH-1:0] ch_ready;
    logic           match_valid;
    logic [1:0]     match_ch;
    logic [CW-1:0]  match_total;

    pattern_detect_scheduler #(
        .NCH     (NCH),
        .PAT_LEN (PAT_LEN),
        .PATTERN (PAT),
        .COUNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_ready    (ch_ready),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_total (match_total)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    bit sq [NCH][$];   // pending stimulus bits per channel
    int m_q [NCH][$];  // model: every bit each channel has delivered since reset
    int m_ptr = 0;
    int e_mv  = 0;
    int e_mch = 0;
    int e_tot = 0;
    int pulse_ch [$];
    int pulse_cyc [$];
    int pulse_tot [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pat_hit(input int c);
        logic [PAT_LEN-1:0] pv;
        int n;
        pv = PAT;
        n  = m_q[c].size();
        if (n < PAT_LEN) return 1'b0;
        for (int j = 0; j < PAT_LEN; j++) begin
            if (m_q[c][n-PAT_LEN+j] != int'(pv[PAT_LEN-1-j])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Check outputs of the current cycle, then apply the upcoming edge to the model.
    always @(negedge clk) begin
        int g;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            if (g < 0 && ch_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
        end
        if (mon_en) begin
            chk("ch_ready", int'(ch_ready), (g < 0) ? 0 : (1 << g));
            chk("match_valid", int'(match_valid), e_mv);
            chk("match_ch", int'(match_ch), e_mch);
            chk("match_total", int'(match_total), e_tot);
            if (match_valid) begin
                pulse_ch.push_back(int'(match_ch));
                pulse_cyc.push_back(cyc);
                pulse_tot.push_back(int'(match_total));
            end
        end
        if (rst) begin
            for (int c = 0; c < NCH; c++) m_q[c].delete();
            m_ptr = 0;
            e_mv  = 0;
            e_mch = 0;
            e_tot = 0;
        end else begin
            e_mv = 0;
            if (g >= 0) begin
                m_q[g].push_back(int'(ch_bit[g]));
                m_ptr = (g + 1) % NCH;
                if (pat_hit(g)) begin
                    e_mv  = 1;
                    e_mch = g;
                    if (CNT_EN && e_tot < (1 << CW) - 1) e_tot++;
                end
            end
        end
    end

    function automatic int pending();
        int n;
        n = 0;
        for (int c = 0; c < NCH; c++) n += sq[c].size();
        return n;
    endfunction

    task automatic present();
        for (int c = 0; c < NCH; c++) begin
            if (sq[c].size() > 0) begin
                ch_valid[c] = 1'b1;
                ch_bit[c]   = sq[c][0];
            end else begin
                ch_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic run_streams();
        logic [NCH-1:0] acc;
        int n;
        n = 0;
        present();
        while (pending() > 0 && n < 200) begin
            @(negedge clk);
            acc = ch_valid & ch_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) if (acc[c]) void'(sq[c].pop_front());
            present();
            n++;
        end
        chk("stream_drain", pending(), 0);
        for (int c = 0; c < NCH; c++) sq[c].delete();
        ch_valid = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_pulses();
        pulse_ch.delete();
        pulse_cyc.delete();
        pulse_tot.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_pulses();
    endtask

    function automatic int pch(input int i);
        return (i < pulse_ch.size()) ? pulse_ch[i] : -1;
    endfunction

    initial begin
        int exp_tot [5];
        exp_tot  = '{1, 2, 3, 3, 3};
        rst      = 1'b1;
        ch_valid = '0;
        ch_bit   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state, and combinational ready with ptr at 0
        @(negedge clk);
        chk("rst_match_valid", int'(match_valid), 0);
        chk("rst_match_ch", int'(match_ch), 0);
        chk("rst_match_total", int'(match_total), 0);
        chk("rst_ch_ready_idle", int'(ch_ready), 0);
        @(posedge clk);
        #1;
        ch_valid = 4'b1010;
        #1;
        chk("rst_ch_ready_1010", int'(ch_ready), 4'b0010);
        ch_valid = 4'b1100;
        #1;
        chk("rst_ch_ready_1100", int'(ch_ready), 4'b0100);
        ch_valid = '0;
        @(posedge clk);
        #1;

        // Basic 1,0,1 on ch0
        clear_pulses();
        sq[0] = '{1, 0, 1};
        run_streams();
        chk("t1_pulses", pulse_ch.size(), 1);
        chk("t1_ch", pch(0), 0);

        // Overlapping matches on ch2
        clear_pulses();
        sq[2] = '{1, 0, 1, 0, 1};
        run_streams();
        chk("t2_pulses", pulse_ch.size(), 2);
        chk("t2_ch0", pch(0), 2);
        chk("t2_ch1", pch(1), 2);
        if (pulse_cyc.size() == 2) chk("t2_spacing", pulse_cyc[1] - pulse_cyc[0], 2);

        // Fairness: all channels from ptr=0
        do_reset();
        for (int c = 0; c < NCH; c++) sq[c] = '{1, 0, 1};
        run_streams();
        chk("t3_pulses", pulse_ch.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_order", pch(i), i);
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk("t3_consecutive", pulse_cyc[i] - pulse_cyc[i-1], 1);

        // Isolation between ch1 and ch3
        do_reset();
        sq[1] = '{1, 0, 1};
        sq[3] = '{1};
        run_streams();
        chk("t4_pulses", pulse_ch.size(), 1);
        chk("t4_ch", pch(0), 1);

        // Mid-stream reset discards history
        do_reset();
        sq[0] = '{1, 0};
        run_streams();
        do_reset();
        sq[0] = '{1};
        run_streams();
        chk("t5_no_match", pulse_ch.size(), 0);
        sq[0] = '{0, 1};
        run_streams();
        chk("t5_match", pulse_ch.size(), 1);

        // Five matches: saturating counter
        do_reset();
        sq[0] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        run_streams();
        chk("t6_pulses", pulse_tot.size(), 5);
        for (int i = 0; i < pulse_tot.size() && i < 5; i++)
            chk("t6_total", pulse_tot[i], CNT_EN ? exp_tot[i] : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
